// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states, helpers.
package mem_lsu_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;
   localparam logic [3:0] OP_LL  = 4'd9;
   localparam logic [3:0] OP_SC  = 4'd10;

   localparam logic [63:0] ZERO_WORD = 64'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } acc_size_e;

   function automatic logic op_is_load(input logic [3:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW) || (op == OP_LL);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
   endfunction

   function automatic acc_size_e op_size(input logic [3:0] op);
      if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB)) return SZ_BYTE;
      if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) return SZ_HALF;
      return SZ_WORD;
   endfunction

endpackage

// File: rtl/mem_lsu_load_ext.sv
// Selects the addressed big-endian byte lanes of a bus read and extends to DATA_W.
module mem_load_ext
   import mem_lsu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [3:0]                      op,
   input  logic [$clog2(DATA_W/8)-1:0]     off,
   input  logic [DATA_W-1:0]               rdata,
   output logic [DATA_W-1:0]               result
);

   logic [DATA_W-1:0] aligned;

   // Shift the addressed byte to the top lane; offset 0 is the MSB lane.
   always_comb begin
      aligned = rdata << {off, 3'b000};
   end

   // Extend the selected field according to the load flavour.
   always_comb begin
      result = DATA_W'(ZERO_WORD);
      case (op)
         OP_LB:   result = DATA_W'($signed(aligned[DATA_W-1 -: 8]));
         OP_LBU:  result = DATA_W'(aligned[DATA_W-1 -: 8]);
         OP_LH:   result = DATA_W'($signed(aligned[DATA_W-1 -: 16]));
         OP_LHU:  result = DATA_W'(aligned[DATA_W-1 -: 16]);
         default: result = DATA_W'($signed(aligned[DATA_W-1 -: 32]));
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: drives a single-outstanding bus access and
// stalls the pipeline until the data is back, with LL/SC link-bit support.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned RA_W   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RA_W-1:0]       ex_waddr,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic                  ex_we,
   input  logic [3:0]            ex_op,
   input  logic [ADDR_W-1:0]     ex_maddr,
   input  logic [DATA_W-1:0]     ex_sdata,
   input  logic                  llbit_clr,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic [DATA_W/8-1:0]   bus_sel,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic [DATA_W-1:0]     bus_rdata,
   input  logic                  bus_ack,
   output logic [RA_W-1:0]       mem_waddr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   output logic                  mem_we_o,
   output logic                  stall_req,
   output logic                  align_exc
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam logic [NB-1:0] ONES  = '1;
   localparam logic [NB-1:0] SEL_B = ONES << (NB - 1);
   localparam logic [NB-1:0] SEL_H = ONES << (NB - 2);
   localparam logic [NB-1:0] SEL_W = ONES << (NB - 4);

   lsu_state_e        state_q;
   logic              llbit_q;
   logic [DATA_W-1:0] cap_q;

   logic [OFF_W-1:0]  off;
   acc_size_e         size;
   logic              is_load;
   logic              is_store;
   logic              mem_op;
   logic              misaligned;
   logic              sc_fail;
   logic              start;
   logic [NB-1:0]     sel_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [DATA_W-1:0] ext_data;

   mem_load_ext #(.DATA_W(DATA_W)) u_load_ext (
      .op     (ex_op),
      .off    (off),
      .rdata  (bus_rdata),
      .result (ext_data)
   );

   // Decode the op and work out alignment, lane enables and store data.
   always_comb begin
      off        = ex_maddr[OFF_W-1:0];
      size       = op_size(ex_op);
      is_load    = op_is_load(ex_op);
      is_store   = op_is_store(ex_op);
      mem_op     = is_load || is_store;
      misaligned = 1'b0;
      sel_nxt    = SEL_W >> off;
      wdata_nxt  = {(DATA_W/32){ex_sdata[31:0]}};
      case (size)
         SZ_BYTE: begin
            sel_nxt   = SEL_B >> off;
            wdata_nxt = {(DATA_W/8){ex_sdata[7:0]}};
         end
         SZ_HALF: begin
            misaligned = off[0];
            sel_nxt    = SEL_H >> off;
            wdata_nxt  = {(DATA_W/16){ex_sdata[15:0]}};
         end
         default: misaligned = (off[1:0] != 2'b00);
      endcase
      sc_fail = (ex_op == OP_SC) && !llbit_q;
      start   = (state_q == ST_IDLE) && mem_op && !misaligned && !sc_fail;
   end

   // Access sequencing, bus drive, load capture and link bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_sel   <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         llbit_q   <= 1'b0;
         cap_q     <= DATA_W'(ZERO_WORD);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  bus_req   <= 1'b1;
                  bus_we    <= is_store;
                  bus_addr  <= {ex_maddr[ADDR_W-1:OFF_W], OFF_W'(0)};
                  bus_sel   <= sel_nxt;
                  bus_wdata <= wdata_nxt;
                  state_q   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  bus_sel <= '0;
                  cap_q   <= (ex_op == OP_SC) ? DATA_W'(1) : ext_data;
                  if (ex_op == OP_LL) llbit_q <= 1'b1;
                  if (ex_op == OP_SC) llbit_q <= 1'b0;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
         // An exception/eret clear overrides an LL setting the bit.
         if (llbit_clr) llbit_q <= 1'b0;
      end
   end

   // Writeback, stall and alignment outputs, forced quiet while in reset.
   always_comb begin
      mem_waddr_o = ex_waddr;
      mem_wdata_o = ex_wdata;
      mem_we_o    = ex_we;
      stall_req   = 1'b0;
      align_exc   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               if (misaligned) begin
                  align_exc = 1'b1;
                  mem_we_o  = 1'b0;
               end else if (sc_fail) begin
                  mem_wdata_o = DATA_W'(ZERO_WORD);
               end else begin
                  stall_req = 1'b1;
                  mem_we_o  = 1'b0;
               end
            end
         end
         ST_BUSY: begin
            stall_req = 1'b1;
            mem_we_o  = 1'b0;
         end
         ST_DONE: begin
            if (is_load || (ex_op == OP_SC)) mem_wdata_o = cap_q;
         end
         default: ;
      endcase
      if (rst) begin
         mem_waddr_o = '0;
         mem_wdata_o = DATA_W'(ZERO_WORD);
         mem_we_o    = 1'b0;
         stall_req   = 1'b0;
         align_exc   = 1'b0;
      end
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DATA_W, default 32, datapath and bus data width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 32, memory address width.
REQ-003 Parameter RA_W, default 5, register-file address width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ex_waddr  in  RA_W  destination register from ex_mem.
REQ-007 ex_wdata  in  DATA_W  ALU result from ex_mem; passed through for non-load ops.
REQ-008 ex_we  in  1  register write enable from ex_mem.
REQ-009 ex_op  in  4  memory op code; package constant values.
REQ-010 ex_maddr  in  ADDR_W  effective memory address.
REQ-011 ex_sdata  in  DATA_W  store data.
REQ-012 llbit_clr  in  1  exception/eret pulse clearing the link bit.
REQ-013 bus_req, bus_we  out  1 each  registered bus request and write strobe.
REQ-014 bus_addr  out  ADDR_W  registered, low log2(DATA_W/8) bits forced 0.
REQ-015 bus_sel  out  DATA_W/8  registered byte-lane enables.
REQ-016 bus_wdata  out  DATA_W  registered, store bytes replicated to all lanes.
REQ-017 bus_rdata  in  DATA_W; bus_ack  in  1  read data valid with ack.
REQ-018 mem_waddr_o  out  RA_W; mem_wdata_o  out  DATA_W; mem_we_o  out  1  writeback to mem_wb.
REQ-019 stall_req  out  1  freezes all upstream pipeline stages.
REQ-020 align_exc  out  1  misaligned access pulse.

Function
REQ-021 Ops SHALL be NOP, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC.
REQ-022 Non-memory ops: mem_*_o SHALL equal ex_* combinationally, zero latency, stall_req=0.
REQ-023 FSM states SHALL be IDLE, BUSY, DONE.
REQ-024 IDLE with a valid aligned memory op: stall_req=1 combinationally; next edge -> BUSY, bus_req=1 with addr/sel/we/wdata loaded.
REQ-025 BUSY: stall_req=1, bus signals held stable until the bus_ack cycle; on ack, bus_req=0 next edge, load data captured in a register, -> DONE.
REQ-026 DONE, exactly one cycle: stall_req=0, mem_wdata_o = captured extended load data (or SC result), mem_we_o = ex_we; -> IDLE.
REQ-027 Byte lanes big-endian: byte offset 0 = most significant lane.
REQ-028 LB/LH SHALL sign-extend to DATA_W; LBU/LHU zero-extend; LW on 64-bit bus selects half by addr[2] and sign-extends.
REQ-029 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0.
REQ-030 Misaligned op: align_exc=1 combinationally for that cycle, no bus access, mem_we_o=0, stall_req=0, LLbit unchanged.
REQ-031 LL: behaves as LW; LLbit set at the ack edge.
REQ-032 SC with LLbit=1: performs word store, DONE writes 1 to rd; with LLbit=0: no bus access, no stall, rd written 0 in the same cycle.
REQ-033 SC completion (either outcome) SHALL clear LLbit.
REQ-034 llbit_clr in the same cycle as an LL ack: clear wins, LLbit=0.
REQ-035 bus_ack while IDLE or DONE SHALL be ignored.
REQ-036 Stores SHALL set mem_we_o = ex_we in DONE; mem_wdata_o = ex_wdata.

Reset
REQ-037 rst=1 SHALL force mem_waddr_o=0, mem_wdata_o=0, mem_we_o=0, stall_req=0, align_exc=0 combinationally.
REQ-038 At a rst edge: state=IDLE, bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, LLbit=0, capture register=0.
REQ-039 rst during BUSY SHALL abandon the access; a late bus_ack after reset SHALL be ignored.

Structure
REQ-040 Op codes, FSM state encoding and ZeroWord constant SHALL live in the shared defines package.
REQ-041 Load byte-lane extraction and extension SHALL be one sub-module, mem_load_ext, purely combinational.

Verification
REQ-042 ALU passthrough: op=NOP, waddr=3, wdata=0x12345678, we=1 -> same values on mem_*_o same cycle, stall_req=0.
REQ-043 LB addr=0x1001, bus_rdata=0x00F00000, ack after 3 BUSY cycles -> sel=0100, stall_req high 4 cycles, DONE writes 0xFFFFFFF0; LBU writes 0x000000F0.
REQ-044 SH addr=0x2002, sdata=0x0000BEEF -> bus_sel=0011, bus_wdata=0xBEEFBEEF, bus_we=1.
REQ-045 LW addr=0x0003 -> align_exc=1 one cycle, bus_req stays 0, mem_we_o=0.
REQ-046 LL 0x40, then SC 0x40 -> store, rd=1; second SC -> no bus access, rd=0; LL with llbit_clr at ack -> following SC rd=0.
REQ-047 rst asserted in BUSY, ack arrives next cycle -> bus_req=0, state IDLE, no writeback, stall_req=0.
